// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the toggle-flip-flop counter controller.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_counter_ctrl_toggle_bank.sv
// Bank of W T-flip-flops with synchronous active-high reset; bit i flips when i_t_vec[i]=1.
module toggle_bank #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_t_vec,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) r_q <= '0;
    else       r_q <= r_q ^ i_t_vec;
  end

  assign o_q = r_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Modulo up/down counter controller driving a toggle bank purely through per-bit toggle enables.
// Handshake: start is accepted only in IDLE with stop low; done is a one-cycle pulse, busy covers RUN and DONE.
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         dir,
  input  logic [W-1:0] limit,
  input  logic         auto_reload,
  output logic [W-1:0] count,
  output logic [W-1:0] t_vec,
  output logic         busy,
  output logic         done,
  output logic         wrap,
  output state_t       dbg_state
);

  state_t       r_state;
  state_t       w_next_state;
  logic         r_dir;
  logic [W-1:0] r_limit;
  logic         r_reload;
  logic         r_wrap;
  logic         w_wrap_set;
  logic         w_capture;
  logic [W-1:0] w_t_vec;
  logic [W-1:0] w_step_t;
  logic [W-1:0] w_term;
  logic [W-1:0] w_reload_val;
  logic         w_ones;
  logic         w_zeros;

  toggle_bank #(.W(W)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .i_t_vec (w_t_vec),
    .o_q     (count)
  );

  // Single-step toggles: up flips bit i when all lower bits are 1, down when all are 0.
  always_comb begin
    w_step_t    = '0;
    w_step_t[0] = 1'b1;
    w_ones      = count[0];
    w_zeros     = ~count[0];
    for (int i = 1; i < W; i++) begin
      w_step_t[i] = (r_dir == DIR_DOWN) ? w_zeros : w_ones;
      w_ones      = w_ones & count[i];
      w_zeros     = w_zeros & ~count[i];
    end
  end

  assign w_term       = (r_dir == DIR_DOWN) ? '0 : r_limit;
  assign w_reload_val = (r_dir == DIR_DOWN) ? r_limit : '0;

  always_comb begin
    w_next_state = r_state;
    w_t_vec      = '0;
    w_wrap_set   = 1'b0;
    w_capture    = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            w_capture    = 1'b1;
            w_t_vec      = count ^ ((dir == DIR_DOWN) ? limit : '0);
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_next_state = ST_IDLE;
          end else if (!pause) begin
            if (count != w_term) begin
              w_t_vec = w_step_t;
            end else if (r_reload) begin
              w_t_vec    = count ^ w_reload_val;
              w_wrap_set = 1'b1;
            end else begin
              w_next_state = ST_DONE;
            end
          end
        end
        ST_DONE: w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dir    <= 1'b0;
      r_limit  <= '0;
      r_reload <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wrap  <= w_wrap_set;
      if (w_capture) begin
        r_dir    <= dir;
        r_limit  <= limit;
        r_reload <= auto_reload;
      end
    end
  end

  assign t_vec     = w_t_vec;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign wrap      = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl: table of per-cycle vectors plus a few randomised runs, scoreboard-checked.
module tb_tff_counter_ctrl;
  import tff_ctrl_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] count, t_vec;
  logic         busy, done, wrap;
  state_t       dbg_state;

  typedef struct {
    logic         rst, st, sp, pa, d;
    logic [W-1:0] lim;
    logic         rl;
    logic [W-1:0] e_count;
    logic         e_busy, e_done, e_wrap;
    logic         chk_t;
    logic [W-1:0] e_t;
  } vec_t;

  vec_t         tbl[$];
  logic [W+2:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           vec_idx = 0;

  tff_counter_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .dir(dir),
    .limit(limit), .auto_reload(auto_reload), .count(count), .t_vec(t_vec),
    .busy(busy), .done(done), .wrap(wrap), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, st, sp, pa, d, input logic [W-1:0] lim,
                              input logic rl, input logic [W-1:0] ec, input logic eb, ed, ew,
                              input logic ct, input logic [W-1:0] et);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.pa = pa; v.d = d; v.lim = lim; v.rl = rl;
    v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew; v.chk_t = ct; v.e_t = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d: got %0h want %0h", name, vec_idx, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge; t_vec is checked before the edge, the rest after it.
  task automatic run_vec(input vec_t v);
    logic [W+2:0] e;
    @(negedge clk);
    reset = v.rst; start = v.st; stop = v.sp; pause = v.pa; dir = v.d;
    limit = v.lim; auto_reload = v.rl;
    #1;
    if (v.chk_t) chk("t_vec", t_vec, v.e_t);
    exp_q.push_back({v.e_count, v.e_busy, v.e_done, v.e_wrap});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard vec=%0d: queue empty", vec_idx);
    end else begin
      e = exp_q.pop_front();
      chk("count", count, e[W+2:3]);
      chk("busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, e[2]});
      chk("done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, e[1]});
      chk("wrap", {{(W-1){1'b0}}, wrap}, {{(W-1){1'b0}}, e[0]});
    end
    vec_idx++;
  endtask

  initial begin
    int lim_r, d_r;
    // reset
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 1,0));
    tbl.push_back(mk(1,1,0,0,1,7,1, 0,0,0,0, 1,0));
    // up, limit=3, no reload
    tbl.push_back(mk(0,1,0,0,0,3,0, 0,1,0,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,3,0, 1,1,0,0, 1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0,3,0, 2,1,0,0, 1,4'b0011));
    tbl.push_back(mk(0,0,0,0,0,3,0, 3,1,0,0, 1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0,3,0, 3,1,1,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,3,0, 3,0,0,0, 1,4'b0000));
    // start+stop together in IDLE
    tbl.push_back(mk(0,1,1,0,1,9,0, 3,0,0,0, 1,4'b0000));
    // down, limit=5, auto reload; config inputs change after capture
    tbl.push_back(mk(0,1,0,0,1,5,1, 5,1,0,0, 1,4'b0110));
    for (int k = 4; k >= 0; k--) tbl.push_back(mk(0,0,0,0,0,2,0, k[W-1:0],1,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,2,0, 5,1,0,1, 1,4'b0101));
    for (int k = 4; k >= 0; k--) tbl.push_back(mk(0,0,0,0,0,2,0, k[W-1:0],1,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,2,0, 5,1,0,1, 1,4'b0101));
    tbl.push_back(mk(0,0,0,0,0,2,0, 4,1,0,0, 0,0));
    tbl.push_back(mk(0,0,1,0,0,2,0, 4,0,0,0, 1,4'b0000));
    // up, limit=15, pause at 7
    tbl.push_back(mk(0,1,0,0,0,15,0, 0,1,0,0, 1,4'b0100));
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(0,0,0,0,0,15,0, k[W-1:0],1,0,0, 0,0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,1,0,15,0, 7,1,0,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,15,0, 8,1,0,0, 1,4'b1111));
    for (int k = 9; k <= 15; k++) tbl.push_back(mk(0,0,0,0,0,15,0, k[W-1:0],1,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,15,0, 15,1,1,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,15,0, 15,0,0,0, 0,0));
    // start during RUN ignored; stop and start during DONE
    tbl.push_back(mk(0,1,0,0,0,2,0, 0,1,0,0, 1,4'b1111));
    tbl.push_back(mk(0,1,0,0,1,9,1, 1,1,0,0, 1,4'b0001));
    tbl.push_back(mk(0,0,0,0,1,9,1, 2,1,0,0, 1,4'b0011));
    tbl.push_back(mk(0,0,0,0,0,9,0, 2,1,1,0, 1,4'b0000));
    tbl.push_back(mk(0,1,1,0,0,9,0, 2,0,0,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,9,0, 2,0,0,0, 0,0));
    // limit=0, no reload
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,1,0,0, 1,4'b0010));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,1,1,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0));
    // limit=0, reload every RUN cycle
    tbl.push_back(mk(0,1,0,0,0,0,1, 0,1,0,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,1,0,1, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,1,0,1, 0,0));
    tbl.push_back(mk(0,0,1,0,0,0,1, 0,0,0,0, 1,4'b0000));
    // reset mid-run at count 5
    tbl.push_back(mk(0,1,0,0,0,9,0, 0,1,0,0, 0,0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(0,0,0,0,0,9,0, k[W-1:0],1,0,0, 0,0));
    tbl.push_back(mk(1,1,0,0,0,9,0, 0,0,0,0, 1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,9,0, 0,0,0,0, 0,0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Randomised full runs without reload; expectations follow from the limit alone.
    for (int r = 0; r < 4; r++) begin
      lim_r = $urandom_range(1, 14);
      d_r   = $urandom_range(0, 1);
      run_vec(mk(0,1,0,0,d_r[0],lim_r[W-1:0],0, (d_r != 0) ? lim_r[W-1:0] : '0, 1,0,0, 0,0));
      for (int k = 1; k <= lim_r; k++) begin
        int c;
        c = (d_r != 0) ? (lim_r - k) : k;
        run_vec(mk(0,0,0,0,0,0,0, c[W-1:0],1,0,0, 0,0));
      end
      run_vec(mk(0,0,0,0,0,0,0, (d_r != 0) ? '0 : lim_r[W-1:0],1,1,0, 1,4'b0000));
      run_vec(mk(0,0,0,0,0,0,0, (d_r != 0) ? '0 : lim_r[W-1:0],0,0,0, 0,0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
